// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one external memory bus between fetch (0), load/store (1) and
// debug/DMA (2). One transaction at a time; a watchdog turns a hung bus cycle into a fault.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [2:0]                  req,
  input  logic [3*ADDR_WIDTH-1:0]     addr,
  input  logic [3*DATA_WIDTH-1:0]     wdata,
  input  logic [2:0]                  we,
  input  logic [3*(DATA_WIDTH/8)-1:0] be,
  output logic [2:0]                  ack,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        fault,
  output logic                        mem_req,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  output logic                        mem_we,
  output logic [DATA_WIDTH/8-1:0]     mem_be,
  input  logic                        mem_ack,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  input  logic                        mem_fault
);

  localparam int unsigned BeWidth  = DATA_WIDTH / 8;
  localparam int unsigned CntWidth = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            last_q, last_d;
  logic [CntWidth-1:0]   wait_cnt_q, wait_cnt_d;
  logic [2:0]            ack_q, ack_d;
  logic                  fault_q, fault_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic [BeWidth-1:0]    mem_be_q, mem_be_d;

  logic [ADDR_WIDTH-1:0] port_addr  [3];
  logic [DATA_WIDTH-1:0] port_wdata [3];
  logic [BeWidth-1:0]    port_be    [3];
  logic [1:0]            winner;

  for (genvar i = 0; i < 3; i++) begin : g_unpack
    assign port_addr[i]  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign port_wdata[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign port_be[i]    = be[i*BeWidth +: BeWidth];
  end

  // Round-robin pick: scan last+1, last+2, last+3 (mod 3); only meaningful when req != 0.
  always_comb begin
    winner = 2'd0;
    case (last_q)
      2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Next-state and registered-output logic for the IDLE/BUSY/DONE transaction FSM.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    wait_cnt_d  = wait_cnt_q;
    ack_d       = ack_q;
    fault_d     = fault_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;

    case (state_q)
      StIdle: begin
        if (req != 3'b000) begin
          grant_d     = winner;
          last_d      = winner;
          mem_addr_d  = port_addr[winner];
          mem_wdata_d = port_wdata[winner];
          mem_we_d    = we[winner];
          mem_be_d    = port_be[winner];
          mem_req_d   = 1'b1;
          wait_cnt_d  = '0;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        // A real bus ack wins over the watchdog when both land in the same cycle.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          ack_d     = 3'b001 << grant_q;
          rdata_d   = mem_rdata;
          fault_d   = mem_fault;
          state_d   = StDone;
        end else if (wait_cnt_q == CntLast) begin
          mem_req_d = 1'b0;
          ack_d     = 3'b001 << grant_q;
          rdata_d   = '0;
          fault_d   = 1'b1;
          state_d   = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StDone: begin
        // req is deliberately not sampled here so the acked port can drop it.
        ack_d   = 3'b000;
        fault_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset clears the bus request asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      grant_q     <= 2'd0;
      last_q      <= 2'd2;
      wait_cnt_q  <= '0;
      ack_q       <= 3'b000;
      fault_q     <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      wait_cnt_q  <= wait_cnt_d;
      ack_q       <= ack_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign ack       = ack_q;
  assign fault     = fault_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: requesters + bus model + reference arbiter.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int TO  = 16;
  localparam int BIG = 32'h7fff_ffff;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [2:0]        req;
  logic [3*AW-1:0]   addr;
  logic [3*DW-1:0]   wdata;
  logic [2:0]        we;
  logic [3*BW-1:0]   be;
  logic [2:0]        ack;
  logic [DW-1:0]     rdata;
  logic              fault;
  logic              mem_req;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_we;
  logic [BW-1:0]     mem_be;
  logic              mem_ack;
  logic [DW-1:0]     mem_rdata;
  logic              mem_fault;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .be        (be),
    .ack       (ack),
    .rdata     (rdata),
    .fault     (fault),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_fault (mem_fault)
  );

  typedef struct {
    int          port;
    logic [DW-1:0] rdata;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic [DW-1:0] hold_rdata = '0;

  // Requester payloads.
  logic [AW-1:0] addr_a  [3];
  logic [DW-1:0] wdata_a [3];
  logic          we_a    [3];
  logic [BW-1:0] be_a    [3];

  // Reference model state.
  int            m_last;
  int            free_at;
  int            exp_rise;
  int            rise_cyc;
  int            busy_end;
  int            bus_ack_at;
  int            force_d;
  logic          mem_req_prev;
  logic [DW-1:0] bus_data;
  logic          bus_fault;
  logic [AW-1:0] lat_addr;
  logic [DW+BW:0] lat_ctl;
  bit            allow_new;
  logic [2:0]    raise_mask;

  exp_t          mon_e;
  logic [2:0]    mon_exp_ack;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Round-robin rule: first asserted port among last+1, last+2, last+3 (mod 3).
  function automatic int rr_pick(logic [2:0] r, int last);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  // Bus latency in BUSY cycles after mem_req rises; >= TO means the watchdog fires.
  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 8)  return int'($urandom_range(0, 2));
    if (r < 11) return int'($urandom_range(3, TO - 2));
    if (r == 11) return TO - 1;
    if (r == 12) return TO;
    if (r == 13) return TO + 1;
    return 1000;
  endfunction

  task automatic new_payload(int i);
    addr_a[i]  = $urandom;
    wdata_a[i] = $urandom;
    we_a[i]    = 1'($urandom_range(0, 1));
    be_a[i]    = BW'($urandom);
  endtask

  task automatic pack();
    for (int i = 0; i < 3; i++) begin
      addr[i*AW +: AW]  = addr_a[i];
      wdata[i*DW +: DW] = wdata_a[i];
      we[i]             = we_a[i];
      be[i*BW +: BW]    = be_a[i];
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_last       = 2;
    free_at      = 0;
    exp_rise     = -1;
    rise_cyc     = 0;
    busy_end     = 0;
    bus_ack_at   = -1;
    mem_req_prev = 1'b0;
    hold_rdata   = '0;
    req          = 3'b000;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
    mem_fault    = 1'b0;
  endtask

  // One cycle of stimulus: predict grants, drive the bus, update requesters.
  task automatic step();
    logic rose;
    int   w;
    int   d;
    int   ackc;
    @(negedge clk);
    rose = mem_req && !mem_req_prev;
    mem_req_prev = mem_req;
    check("grant_timing", 64'(rose), 64'(exp_rise == cyc));
    if (rose) begin
      w = rr_pick(req, m_last);
      if (w < 0) w = 0;
      m_last = w;
      check("grant_addr", 64'(mem_addr), 64'(addr_a[w]));
      check("grant_wctl", 64'({mem_we, mem_be, mem_wdata}), 64'({we_a[w], be_a[w], wdata_a[w]}));
      lat_addr  = addr_a[w];
      lat_ctl   = {we_a[w], be_a[w], wdata_a[w]};
      d         = (force_d >= 0) ? force_d : pick_delay();
      bus_data  = $urandom;
      bus_fault = ($urandom_range(0, 3) == 0);
      if (d < TO) begin
        ackc = cyc + d + 1;
        sb.push_back('{w, bus_data, bus_fault, ackc});
      end else begin
        ackc = cyc + TO;
        sb.push_back('{w, DW'(0), 1'b1, ackc});
      end
      bus_ack_at = (d <= TO + 1) ? cyc + d : -1;
      rise_cyc   = cyc;
      busy_end   = ackc;
      free_at    = ackc + 1;
    end else begin
      if (exp_rise == cyc) free_at = cyc;
      if (cyc > rise_cyc && cyc < busy_end) begin
        check("busy_mem_req", 64'(mem_req), 64'd1);
        check("busy_addr", 64'(mem_addr), 64'(lat_addr));
        check("busy_wctl", 64'({mem_we, mem_be, mem_wdata}), 64'(lat_ctl));
      end
    end

    if (bus_ack_at == cyc) begin
      mem_ack   = 1'b1;
      mem_rdata = bus_data;
      mem_fault = bus_fault;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      mem_fault = 1'($urandom_range(0, 1));
    end

    for (int i = 0; i < 3; i++) begin
      if (ack[i]) begin
        req[i] = 1'b0;
      end else if (!req[i] && (raise_mask[i] || (allow_new && $urandom_range(0, 2) == 0))) begin
        req[i] = 1'b1;
        new_payload(i);
      end
    end
    pack();

    if (cyc >= free_at && req != 3'b000) begin
      exp_rise = cyc + 1;
      free_at  = BIG;
    end
  endtask

  task automatic drain();
    allow_new = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (sb.size() == 0 && req == 3'b000) break;
      step();
    end
    check("drain_queue", 64'(sb.size()), 64'd0);
    check("drain_mem_req", 64'(mem_req), 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an ack.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ack != 3'b000) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 64'(ack), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          mon_exp_ack = 3'(1 << mon_e.port);
          check("ack_port", 64'(ack), 64'(mon_exp_ack));
          check("ack_rdata", 64'(rdata), 64'(mon_e.rdata));
          check("ack_fault", 64'(fault), 64'(mon_e.fault));
          check("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("ack_mem_req", 64'(mem_req), 64'd0);
          hold_rdata = mon_e.rdata;
        end
      end else begin
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
          mon_e = sb.pop_front();
          mon_exp_ack = 3'(1 << mon_e.port);
          check("ack_missing", 64'(ack), 64'(mon_exp_ack));
          hold_rdata = mon_e.rdata;
        end
        check("idle_fault", 64'(fault), 64'd0);
        check("rdata_hold", 64'(rdata), 64'(hold_rdata));
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    allow_new  = 1'b0;
    raise_mask = 3'b000;
    force_d    = -1;
    for (int i = 0; i < 3; i++) new_payload(i);
    pack();
    model_reset();

    repeat (3) @(negedge clk);
    check("reset_ack", 64'(ack), 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    check("reset_fault", 64'(fault), 64'd0);
    check("reset_mem_req", 64'(mem_req), 64'd0);
    check("reset_mem_addr", 64'(mem_addr), 64'd0);
    check("reset_mem_wctl", 64'({mem_we, mem_be, mem_wdata}), 64'd0);
    reset_n = 1'b1;
    #1 mon_en = 1'b1;

    // Ports 0 and 1 together out of reset, then random traffic.
    raise_mask = 3'b011;
    step();
    raise_mask = 3'b000;
    allow_new  = 1'b1;
    repeat (1500) step();
    drain();

    // Hang a port-1 transaction and reset it mid-BUSY.
    force_d    = 1000;
    raise_mask = 3'b010;
    step();
    raise_mask = 3'b000;
    repeat (4) step();
    #2;
    reset_n = 1'b0;
    mon_en  = 1'b0;
    #1;
    check("midrst_mem_req", 64'(mem_req), 64'd0);
    check("midrst_ack", 64'(ack), 64'd0);
    check("midrst_rdata", 64'(rdata), 64'd0);
    model_reset();
    force_d = -1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 mon_en = 1'b1;

    // All three request after reset: port 0 must win first.
    raise_mask = 3'b111;
    step();
    raise_mask = 3'b000;
    allow_new  = 1'b1;
    repeat (500) step();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
